// File: rtl/cseq_pkg.sv
// Shared types for the counter sequencer: FSM state, captured job, default width.
// Optional macro CSEQ_REPEAT_EN adds a repeat bit to the job.
package cseq_pkg;

   localparam int CSEQ_WIDTH = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } cseq_state_e;

   // Field widths follow CSEQ_WIDTH; the top's WIDTH parameter defaults to it.
   typedef struct packed {
      logic [CSEQ_WIDTH-1:0] start;
      logic                  dir;
      logic [CSEQ_WIDTH-1:0] len;
`ifdef CSEQ_REPEAT_EN
      logic                  rpt;
`endif
   } cseq_job_t;

endpackage

// File: rtl/counter_seq.sv
// Job sequencer driving an external up/down counter: load, count len enabled cycles, report.
// Optional macro CSEQ_REPEAT_EN adds cmd_repeat for self-restarting jobs.
module counter_seq
   import cseq_pkg::*;
#(
   parameter int WIDTH = CSEQ_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_start,
   input  logic             cmd_dir,
   input  logic [WIDTH-1:0] cmd_len,
`ifdef CSEQ_REPEAT_EN
   input  logic             cmd_repeat,
`endif
   input  logic             abort,
   output logic             load_n,
   output logic             up_down,
   output logic             ce,
   output logic [WIDTH-1:0] data_load,
   input  logic [WIDTH-1:0] count_out,
   input  logic             max_count,
   input  logic             zero,
   output logic             busy,
   output logic             done,
   output logic             wrapped,
   output logic             aborted
);

   cseq_state_e      state, state_nxt;
   cseq_job_t        job;
   logic [WIDTH-1:0] remaining;
   logic             wrapped_q, aborted_q;
   logic             term;
   logic             cnt_unused;

   // count_out is observed by the integrator only; the flags carry what we need.
   assign cnt_unused = ^count_out;

   assign term = job.dir ? max_count : zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (cmd_valid) state_nxt = S_LOAD;
         S_LOAD: begin
            if (abort)              state_nxt = S_DONE;
            else if (job.len != '0) state_nxt = S_RUN;
            else                    state_nxt = S_DONE;
         end
         S_RUN:  if (abort || remaining == WIDTH'(1)) state_nxt = S_DONE;
         S_DONE: begin
`ifdef CSEQ_REPEAT_EN
            state_nxt = (job.rpt && !aborted_q) ? S_LOAD : S_IDLE;
`else
            state_nxt = S_IDLE;
`endif
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         job       <= '0;
         remaining <= '0;
         wrapped_q <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  job.start <= cmd_start;
                  job.dir   <= cmd_dir;
                  job.len   <= cmd_len;
`ifdef CSEQ_REPEAT_EN
                  job.rpt   <= cmd_repeat;
`endif
                  wrapped_q <= 1'b0;
                  aborted_q <= 1'b0;
               end
            end
            S_LOAD: begin
               remaining <= job.len;
               if (abort) aborted_q <= 1'b1;
            end
            S_RUN: begin
               remaining <= remaining - WIDTH'(1);
               if (term)  wrapped_q <= 1'b1;
               if (abort) aborted_q <= 1'b1;
            end
            S_DONE: begin
`ifdef CSEQ_REPEAT_EN
               // Each repeat pass reports its own flags.
               if (state_nxt == S_LOAD) begin
                  wrapped_q <= 1'b0;
                  aborted_q <= 1'b0;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   assign cmd_ready = (state == S_IDLE);
   assign load_n    = (state != S_LOAD);
   assign ce        = (state == S_RUN);
   assign busy      = (state == S_LOAD) || (state == S_RUN);
   assign done      = (state == S_DONE);
   assign up_down   = job.dir;
   assign data_load = job.start;
   assign wrapped   = wrapped_q;
   assign aborted   = aborted_q;

endmodule
